cnn_ci_feeder: RTL and testbench
================================

CNN_CI_FEEDER -- requirements
Module: cnn_ci_feeder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_LEN, 8, bits per element
- ICH, 3, input channels
- IX, 7, input width
- IY, 4, input height
- KX, 3, kernel width
- KY, 3, kernel height
- OX, 5, output width
- OY, 2, output height
REQ-002 Ports (name direction width meaning), one per line:
- clk in 1 clock
- reset_n in 1 async active-low reset
- i_soft_reset in 1 sync clear
- i_wr_valid in 1 load word valid
- i_wr_sel in 1 0=fmap, 1=weight
- i_wr_data in DATA_LEN load word
- o_wr_ready out 1 load word accepted
- i_start in 1 run request
- o_in_valid out 1 to accumulator i_in_valid
- o_in_fmap out ICH*IX*IY*DATA_LEN packed fmap
- o_cnn_weight out ICH*KX*KY*DATA_LEN packed weights
- o_acc_soft_reset out 1 to accumulator i_soft_reset
- i_ot_valid in 1 from accumulator o_ot_valid
- i_ot_ci_acc in OX*OY*DATA_LEN accumulator result
- o_rd_valid out 1 result word valid
- i_rd_ready in 1 result word taken
- o_rd_data out DATA_LEN result word
- o_rd_last out 1 final result word
- o_busy out 1 state != LOAD
- o_timeout out 1 sticky watchdog flag

Function
REQ-003 The FSM SHALL have states LOAD, RUN, CLEAR, DRAIN.
REQ-004 In LOAD, o_wr_ready SHALL be 1 iff the pointer selected by i_wr_sel is below its depth (ICH*IX*IY for fmap, ICH*KX*KY for weight).
REQ-005 Each handshake (i_wr_valid & o_wr_ready) SHALL write i_wr_data to element [ptr*DATA_LEN +: DATA_LEN] of the selected buffer and increment that pointer; writes at a full buffer are dropped.
REQ-006 i_start in LOAD with both buffers full SHALL go to RUN next cycle; otherwise i_start SHALL be ignored.
REQ-007 In RUN, o_in_valid SHALL be 1, and buffers SHALL be frozen.
REQ-008 In RUN, i_ot_valid=1 SHALL capture i_ot_ci_acc into a result register, deassert o_in_valid, and go to CLEAR.
REQ-009 CLEAR SHALL last one cycle with o_acc_soft_reset=1, then go to DRAIN.
REQ-010 In DRAIN, o_rd_data SHALL be result element rd_idx, starting at 0, and o_rd_valid SHALL be 1.
REQ-011 Each o_rd_valid & i_rd_ready handshake SHALL increment rd_idx; o_rd_last=1 iff rd_idx==OX*OY-1.
REQ-012 The handshake on the last word SHALL return to LOAD with both write pointers and rd_idx cleared; buffer contents are retained.
REQ-013 o_rd_data SHALL be held stable while o_rd_valid=1 and i_rd_ready=0.
REQ-014 In any state other than LOAD, o_wr_ready SHALL be 0.
REQ-015 o_acc_soft_reset SHALL be the OR of i_soft_reset and the CLEAR/timeout pulse.

Reset
REQ-016 reset_n=0 SHALL asynchronously force LOAD, clear pointers, rd_idx, buffers, and result, and drive o_wr_ready=1, o_timeout=0, and all other outputs 0.
REQ-017 i_soft_reset=1 SHALL have the same effect synchronously, in any state including mid-RUN or mid-DRAIN, and SHALL take priority over every other event in that cycle.

Configuration
REQ-018 With CNN_FEEDER_TIMEOUT_EN defined, an 8-bit counter SHALL run in RUN.
REQ-019 With CNN_FEEDER_TIMEOUT_EN defined, reaching 255 without i_ot_valid SHALL set o_timeout, pulse o_acc_soft_reset for one cycle, and return to LOAD with pointers cleared.
REQ-020 With CNN_FEEDER_TIMEOUT_EN defined, o_timeout SHALL clear only on reset or soft reset.
REQ-021 Without CNN_FEEDER_TIMEOUT_EN, RUN SHALL wait indefinitely and o_timeout SHALL be tied to 0.

Verification
REQ-022 Load 84 fmap words k and 27 weight words 1, then i_start -> o_in_valid=1, o_in_fmap element 5 = 5, weight element 26 = 1.
REQ-023 In RUN, drive i_ot_valid with result elements 0..9 = 10..19 -> one-cycle o_acc_soft_reset, then 10 words 10..19 with o_rd_last only on 19.
REQ-024 Pulse i_start after only 83 fmap words -> stays LOAD; an 85th fmap write is refused (o_wr_ready=0 when full).
REQ-025 Toggle i_rd_ready 0/1 during DRAIN -> no word lost or duplicated; o_rd_data stable while stalled.
REQ-026 Assert i_soft_reset at DRAIN word 4 -> LOAD next cycle, o_rd_valid=0, o_acc_soft_reset=1 that cycle.
REQ-027 With CNN_FEEDER_TIMEOUT_EN, hold i_ot_valid=0 in RUN -> o_timeout=1 after 255 cycles, back in LOAD.

Source files
------------

// File: rtl/cnn_ci_feeder_if.sv
// Load, accumulator and result-drain signals between a host and cnn_ci_feeder.
// master = host/accumulator side, slave = the feeder.
interface cnn_ci_feeder_if #(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned ICH      = 3,
    parameter int unsigned IX       = 7,
    parameter int unsigned IY       = 4,
    parameter int unsigned KX       = 3,
    parameter int unsigned KY       = 3,
    parameter int unsigned OX       = 5,
    parameter int unsigned OY       = 2
) ();
    logic                             i_soft_reset;
    logic                             i_wr_valid;
    logic                             i_wr_sel;
    logic [DATA_LEN-1:0]              i_wr_data;
    logic                             o_wr_ready;
    logic                             i_start;
    logic                             o_in_valid;
    logic [ICH*IX*IY*DATA_LEN-1:0]    o_in_fmap;
    logic [ICH*KX*KY*DATA_LEN-1:0]    o_cnn_weight;
    logic                             o_acc_soft_reset;
    logic                             i_ot_valid;
    logic [OX*OY*DATA_LEN-1:0]        i_ot_ci_acc;
    logic                             o_rd_valid;
    logic                             i_rd_ready;
    logic [DATA_LEN-1:0]              o_rd_data;
    logic                             o_rd_last;
    logic                             o_busy;
    logic                             o_timeout;

    modport master (
        output i_soft_reset, i_wr_valid, i_wr_sel, i_wr_data, i_start, i_ot_valid,
               i_ot_ci_acc, i_rd_ready,
        input  o_wr_ready, o_in_valid, o_in_fmap, o_cnn_weight, o_acc_soft_reset,
               o_rd_valid, o_rd_data, o_rd_last, o_busy, o_timeout
    );

    modport slave (
        input  i_soft_reset, i_wr_valid, i_wr_sel, i_wr_data, i_start, i_ot_valid,
               i_ot_ci_acc, i_rd_ready,
        output o_wr_ready, o_in_valid, o_in_fmap, o_cnn_weight, o_acc_soft_reset,
               o_rd_valid, o_rd_data, o_rd_last, o_busy, o_timeout
    );
endinterface

// File: rtl/cnn_ci_feeder.sv
// Buffers one fmap/weight set, hands it to the CI accumulator, then drains the result.
// Define CNN_FEEDER_TIMEOUT_EN to add an 8-bit RUN watchdog driving o_timeout.
module cnn_ci_feeder #(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned ICH      = 3,
    parameter int unsigned IX       = 7,
    parameter int unsigned IY       = 4,
    parameter int unsigned KX       = 3,
    parameter int unsigned KY       = 3,
    parameter int unsigned OX       = 5,
    parameter int unsigned OY       = 2
) (
    input logic            clk,
    input logic            reset_n,
    cnn_ci_feeder_if.slave bus
);
    localparam int unsigned FmapDepth = ICH * IX * IY;
    localparam int unsigned WgtDepth  = ICH * KX * KY;
    localparam int unsigned ResDepth  = OX * OY;
    localparam int unsigned FpW       = $clog2(FmapDepth + 1);
    localparam int unsigned WpW       = $clog2(WgtDepth + 1);
    localparam int unsigned RiW       = (ResDepth > 1) ? $clog2(ResDepth) : 1;

    localparam logic [FpW-1:0] FmapFull = FpW'(FmapDepth);
    localparam logic [WpW-1:0] WgtFull  = WpW'(WgtDepth);
    localparam logic [RiW-1:0] ResLast  = RiW'(ResDepth - 1);

    typedef enum logic [1:0] {StLoad, StRun, StClear, StDrain} state_e;

    state_e                          state_q;
    logic [FpW-1:0]                  fmap_ptr_q;
    logic [WpW-1:0]                  wgt_ptr_q;
    logic [RiW-1:0]                  rd_idx_q;
    logic [FmapDepth*DATA_LEN-1:0]   fmap_q;
    logic [WgtDepth*DATA_LEN-1:0]    wgt_q;
    logic [ResDepth*DATA_LEN-1:0]    result_q;

    logic                fmap_full;
    logic                wgt_full;
    logic                wr_ready;
    logic                wr_fire;
    logic                timeout_hit;
    logic                to_pulse;
    logic [DATA_LEN-1:0] rd_word;

    assign fmap_full = (fmap_ptr_q == FmapFull);
    assign wgt_full  = (wgt_ptr_q == WgtFull);
    assign wr_ready  = (state_q == StLoad) && (bus.i_wr_sel ? !wgt_full : !fmap_full);
    assign wr_fire   = bus.i_wr_valid && wr_ready;

`ifdef CNN_FEEDER_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       timeout_q;
    logic       to_pulse_q;

    assign timeout_hit = (state_q == StRun) && !bus.i_ot_valid && (to_cnt_q == 8'hFF);
    assign to_pulse    = to_pulse_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            to_pulse_q <= 1'b0;
        end else if (bus.i_soft_reset) begin
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= timeout_hit;
            if (timeout_hit) timeout_q <= 1'b1;
            to_cnt_q <= (state_q == StRun) ? to_cnt_q + 8'd1 : 8'd0;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign to_pulse      = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StLoad;
            fmap_ptr_q <= '0;
            wgt_ptr_q  <= '0;
            rd_idx_q   <= '0;
            fmap_q     <= '0;
            wgt_q      <= '0;
            result_q   <= '0;
        end else if (bus.i_soft_reset) begin
            state_q    <= StLoad;
            fmap_ptr_q <= '0;
            wgt_ptr_q  <= '0;
            rd_idx_q   <= '0;
            fmap_q     <= '0;
            wgt_q      <= '0;
            result_q   <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (wr_fire && !bus.i_wr_sel) begin
                        for (int unsigned i = 0; i < FmapDepth; i++) begin
                            if (fmap_ptr_q == FpW'(i)) fmap_q[i*DATA_LEN +: DATA_LEN] <= bus.i_wr_data;
                        end
                        fmap_ptr_q <= fmap_ptr_q + 1'b1;
                    end
                    if (wr_fire && bus.i_wr_sel) begin
                        for (int unsigned i = 0; i < WgtDepth; i++) begin
                            if (wgt_ptr_q == WpW'(i)) wgt_q[i*DATA_LEN +: DATA_LEN] <= bus.i_wr_data;
                        end
                        wgt_ptr_q <= wgt_ptr_q + 1'b1;
                    end
                    if (bus.i_start && fmap_full && wgt_full) state_q <= StRun;
                end
                StRun: begin
                    if (bus.i_ot_valid) begin
                        result_q <= bus.i_ot_ci_acc;
                        state_q  <= StClear;
                    end else if (timeout_hit) begin
                        state_q    <= StLoad;
                        fmap_ptr_q <= '0;
                        wgt_ptr_q  <= '0;
                        rd_idx_q   <= '0;
                    end
                end
                StClear: state_q <= StDrain;
                StDrain: begin
                    if (bus.i_rd_ready) begin
                        if (rd_idx_q == ResLast) begin
                            // Buffers keep their contents; only the pointers rewind.
                            state_q    <= StLoad;
                            fmap_ptr_q <= '0;
                            wgt_ptr_q  <= '0;
                            rd_idx_q   <= '0;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < ResDepth; i++) begin
            if (rd_idx_q == RiW'(i)) rd_word = result_q[i*DATA_LEN +: DATA_LEN];
        end
    end

    assign bus.o_wr_ready       = wr_ready;
    assign bus.o_in_valid       = (state_q == StRun);
    assign bus.o_in_fmap        = fmap_q;
    assign bus.o_cnn_weight     = wgt_q;
    assign bus.o_acc_soft_reset = bus.i_soft_reset || (state_q == StClear) || to_pulse;
    assign bus.o_rd_valid       = (state_q == StDrain);
    assign bus.o_rd_data        = (state_q == StDrain) ? rd_word : '0;
    assign bus.o_rd_last        = (state_q == StDrain) && (rd_idx_q == ResLast);
    assign bus.o_busy           = (state_q != StLoad);
endmodule

// File: tb/tb_cnn_ci_feeder.sv
// Directed bench for cnn_ci_feeder: load, start gating, run/clear/drain,
// back-pressure, soft reset mid-drain and the RUN watchdog (or its absence).
module tb_cnn_ci_feeder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [79:0] acc;

    cnn_ci_feeder_if bus ();

    cnn_ci_feeder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_watchdog: observed no finish, required finish");
        $fatal(1, "bench timed out");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fm(input int i);
        return bus.o_in_fmap[i*8 +: 8];
    endfunction

    function automatic logic [7:0] wt(input int i);
        return bus.o_cnn_weight[i*8 +: 8];
    endfunction

    task automatic load_all();
        bus.i_wr_valid = 1'b1;
        bus.i_wr_sel   = 1'b0;
        for (int k = 0; k < 84; k++) begin
            bus.i_wr_data = 8'(k);
            step();
        end
        bus.i_wr_sel  = 1'b1;
        bus.i_wr_data = 8'd1;
        repeat (27) step();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_sel   = 1'b0;
    endtask

    task automatic start_run();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic give_result(input int base);
        for (int i = 0; i < 10; i++) acc[i*8 +: 8] = 8'(base + i);
        bus.i_ot_ci_acc = acc;
        bus.i_ot_valid  = 1'b1;
        step();
        bus.i_ot_valid  = 1'b0;
        bus.i_ot_ci_acc = '1;
        #1;
    endtask

    initial begin
        int n;
        bus.i_soft_reset = 1'b0;
        bus.i_wr_valid   = 1'b0;
        bus.i_wr_sel     = 1'b0;
        bus.i_wr_data    = '0;
        bus.i_start      = 1'b0;
        bus.i_ot_valid   = 1'b0;
        bus.i_ot_ci_acc  = '0;
        bus.i_rd_ready   = 1'b0;

        // Reset state
        #2;
        chk("rst_wr_ready", bus.o_wr_ready, 1);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_in_valid", bus.o_in_valid, 0);
        chk("rst_rd_valid", bus.o_rd_valid, 0);
        chk("rst_acc_sr", bus.o_acc_soft_reset, 0);
        chk("rst_timeout", bus.o_timeout, 0);
        chk("rst_rd_data", bus.o_rd_data, 0);
        #10 reset_n = 1'b1;
        step();

        // Start gating on partial fmap, then full-buffer refusal
        bus.i_wr_valid = 1'b1;
        bus.i_wr_sel   = 1'b1;
        bus.i_wr_data  = 8'd1;
        repeat (27) step();
        chk("wgt_full_ready", bus.o_wr_ready, 0);
        bus.i_wr_sel = 1'b0;
        for (int k = 0; k < 83; k++) begin
            bus.i_wr_data = 8'(k);
            step();
        end
        bus.i_wr_valid = 1'b0;
        start_run();
        chk("partial_start_busy", bus.o_busy, 0);
        chk("partial_start_in_valid", bus.o_in_valid, 0);
        chk("fmap_ready_83", bus.o_wr_ready, 1);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 8'd83;
        step();
        chk("fmap_full_ready", bus.o_wr_ready, 0);
        bus.i_wr_data = 8'hAA;
        step();
        bus.i_wr_valid = 1'b0;
        chk("fmap_drop_elem83", fm(83), 8'd83);

        // Run
        start_run();
        chk("run_in_valid", bus.o_in_valid, 1);
        chk("run_busy", bus.o_busy, 1);
        chk("run_fmap5", fm(5), 8'd5);
        chk("run_fmap83", fm(83), 8'd83);
        chk("run_wgt26", wt(26), 8'd1);
        chk("run_wr_ready", bus.o_wr_ready, 0);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 8'h55;
        step();
        step();
        bus.i_wr_valid = 1'b0;
        chk("run_frozen_fmap0", fm(0), 8'd0);
        chk("run_hold_in_valid", bus.o_in_valid, 1);

        // Result capture and clear pulse
        give_result(10);
        chk("clear_in_valid", bus.o_in_valid, 0);
        chk("clear_acc_sr", bus.o_acc_soft_reset, 1);
        chk("clear_rd_valid", bus.o_rd_valid, 0);
        step();
        chk("drain_acc_sr", bus.o_acc_soft_reset, 0);
        chk("drain_rd_valid", bus.o_rd_valid, 1);
        chk("drain_first_data", bus.o_rd_data, 10);

        // Drain with back-pressure
        for (int i = 0; i < 10; i++) begin
            bus.i_rd_ready = 1'b0;
            step();
            chk("stall_data", bus.o_rd_data, 32'(10 + i));
            chk("stall_valid", bus.o_rd_valid, 1);
            bus.i_rd_ready = 1'b1;
            #1;
            chk("word_data", bus.o_rd_data, 32'(10 + i));
            chk("word_last", bus.o_rd_last, (i == 9) ? 1 : 0);
            step();
        end
        bus.i_rd_ready = 1'b0;
        chk("post_drain_busy", bus.o_busy, 0);
        chk("post_drain_rd_valid", bus.o_rd_valid, 0);
        chk("post_drain_wr_ready", bus.o_wr_ready, 1);
        chk("post_drain_retained", fm(5), 8'd5);
        start_run();
        chk("restart_needs_reload", bus.o_busy, 0);

        // Soft reset in the middle of a drain
        load_all();
        start_run();
        give_result(30);
        step();
        bus.i_rd_ready = 1'b1;
        repeat (4) step();
        bus.i_rd_ready = 1'b0;
        #1;
        chk("sr_word4_data", bus.o_rd_data, 34);
        bus.i_soft_reset = 1'b1;
        #1;
        chk("sr_acc_sr_same_cycle", bus.o_acc_soft_reset, 1);
        step();
        bus.i_soft_reset = 1'b0;
        #1;
        chk("sr_busy", bus.o_busy, 0);
        chk("sr_rd_valid", bus.o_rd_valid, 0);
        chk("sr_wr_ready", bus.o_wr_ready, 1);
        chk("sr_fmap_cleared", fm(5), 8'd0);
        chk("sr_wgt_cleared", wt(26), 8'd0);
        chk("sr_acc_sr_low", bus.o_acc_soft_reset, 0);

        // Watchdog behaviour in RUN
        load_all();
        start_run();
`ifdef CNN_FEEDER_TIMEOUT_EN
        n = 0;
        while (n < 400 && !bus.o_timeout) begin
            step();
            n++;
        end
        chk("to_fired_in_window", (n >= 255 && n <= 257) ? 1 : 0, 1);
        chk("to_busy", bus.o_busy, 0);
        chk("to_acc_sr_pulse", bus.o_acc_soft_reset, 1);
        chk("to_wr_ready", bus.o_wr_ready, 1);
        step();
        chk("to_acc_sr_one_cycle", bus.o_acc_soft_reset, 0);
        chk("to_sticky", bus.o_timeout, 1);
        bus.i_soft_reset = 1'b1;
        step();
        bus.i_soft_reset = 1'b0;
        #1;
        chk("to_cleared_by_sr", bus.o_timeout, 0);
`else
        n = 0;
        repeat (300) begin
            step();
            n++;
        end
        chk("no_to_busy", bus.o_busy, 1);
        chk("no_to_in_valid", bus.o_in_valid, 1);
        chk("no_to_flag", bus.o_timeout, 0);
        chk("no_to_acc_sr", bus.o_acc_soft_reset, 0);
        bus.i_soft_reset = 1'b1;
        step();
        bus.i_soft_reset = 1'b0;
        #1;
        chk("no_to_sr_exit", bus.o_busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
